// File: rtl/event_tx.sv
// event_tx: buffers filtered events in a FIFO and serializes each as a start/data/even-parity/stop frame, LSB first
module event_tx #(
  parameter int COORD_W      = 2,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ev_valid,
  input  logic [COORD_W-1:0]            ev_x,
  input  logic [COORD_W-1:0]            ev_y,
  input  logic [COORD_W-1:0]            ev_t,
  input  logic [COORD_W-1:0]            ev_p,
  output logic                          ev_ready,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count
);
  localparam int D  = 4 * COORD_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(D);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t          state;
  logic [D-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [D-1:0]    shift;
  logic            par;
  logic [TW-1:0]   timer;
  logic [BW-1:0]   bit_idx;
  logic            full, empty, push, pop, bit_end;
  assign full     = fifo_level == LW'(FIFO_DEPTH);
  assign empty    = fifo_level == '0;
  assign push     = ev_valid && !full;
  assign pop      = state == IDLE && !empty;
  assign bit_end  = timer == TW'(CLKS_PER_BIT - 1);
  assign ev_ready = !full;
  assign tx_busy  = state != IDLE;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {ev_x, ev_y, ev_t, ev_p};
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_serial  <= 1'b1;
      fifo_level <= '0;
      drop_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      timer      <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      par        <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
      if (ev_valid && full && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
      timer <= (state == IDLE || bit_end) ? '0 : timer + TW'(1);
      case (state)
        IDLE: begin
          tx_serial <= !pop;
          if (pop) begin
            shift <= mem[rd_ptr];
            par   <= ^mem[rd_ptr];
            state <= START;
          end
        end
        START: if (bit_end) begin
          state     <= DATA;
          tx_serial <= shift[0];
          bit_idx   <= '0;
        end
        DATA: if (bit_end) begin
          if (bit_idx == BW'(D - 1)) begin
            state     <= PARITY;
            tx_serial <= par;
          end else begin
            bit_idx   <= bit_idx + BW'(1);
            shift     <= shift >> 1;
            tx_serial <= shift[1];
          end
        end
        PARITY: if (bit_end) begin
          state     <= STOP;
          tx_serial <= 1'b1;
        end
        STOP: if (bit_end) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_event_tx.sv
// tb_event_tx: scoreboard bench decoding serial frames from event_tx against queued expected words
module tb_event_tx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ev_valid = 1'b0;
  logic [1:0] ev_x = '0, ev_y = '0, ev_t = '0, ev_p = '0;
  logic       ev_ready, tx_serial, tx_busy;
  logic [2:0] fifo_level;
  logic [7:0] drop_count;
  int         total = 0;
  int         bad = 0;
  logic [7:0] q [$];
  bit         ign = 1'b0;
  bit         aborted;
  always #5 clk = ~clk;
  event_tx dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid),
    .ev_x(ev_x), .ev_y(ev_y), .ev_t(ev_t), .ev_p(ev_p),
    .ev_ready(ev_ready), .tx_serial(tx_serial), .tx_busy(tx_busy),
    .fifo_level(fifo_level), .drop_count(drop_count)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (rst) aborted = 1'b1;
    end
  endtask
  task automatic send(input logic [7:0] w);
    @(negedge clk);
    {ev_x, ev_y, ev_t, ev_p} = w;
    ev_valid = 1'b1;
    if (!ign) q.push_back(w);
    @(negedge clk);
    ev_valid = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!tx_busy && fifo_level == 0 && q.size() == 0) return;
    end
    total++;
    bad++;
    $display("FAIL wait_idle: got busy=%0d level=%0d pending=%0d, required idle", tx_busy, fifo_level, q.size());
  endtask
  initial begin : mon
    logic       prev, s0, pb, sb, ig;
    logic [7:0] w, exp;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && prev && tx_serial === 1'b0) begin
        ig = ign;
        aborted = 1'b0;
        step(2);
        s0 = tx_serial;
        for (int i = 0; i < 8; i++) begin
          step(4);
          w[i] = tx_serial;
        end
        step(4);
        pb = tx_serial;
        step(4);
        sb = tx_serial;
        if (!ig && !aborted) begin
          if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL frame_unexpected: got word %h, required none", w);
          end else begin
            exp = q.pop_front();
            check("start_bit", s0, 0);
            check("frame_data", w, exp);
            check("parity_bit", pb, ^exp);
            check("stop_bit", sb, 1);
          end
        end
      end
      prev = tx_serial;
    end
  end
  initial begin
    int n;
    bit seen0, found;
    logic [7:0] ow [6];
    ow = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9a, 8'hbc};
    repeat (2) @(negedge clk);
    check("rst_tx", tx_serial, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_count, 0);
    check("rst_ready", ev_ready, 1);
    rst = 1'b0;
    send(8'h9d);
    check("lat_level_n", fifo_level, 1);
    check("lat_tx_n", tx_serial, 1);
    @(negedge clk);
    check("lat_tx_fall", tx_serial, 0);
    check("lat_level_n1", fifo_level, 0);
    check("lat_busy", tx_busy, 1);
    n = 1;
    for (int i = 0; i < 100 && tx_busy; i++) begin
      @(negedge clk);
      if (tx_busy) n++;
    end
    check("busy_cycles", n, 44);
    check("idle_high", tx_serial, 1);
    check("drop_zero", drop_count, 0);
    wait_idle();
    send(8'h00);
    wait_idle();
    send(8'hff);
    wait_idle();
    send(8'h01);
    wait_idle();
    @(negedge clk);
    ev_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      {ev_x, ev_y, ev_t, ev_p} = ow[i];
      if (i < 5) q.push_back(ow[i]);
      @(negedge clk);
    end
    ev_valid = 1'b0;
    check("ovf_drop", drop_count, 1);
    check("ovf_level", fifo_level, 4);
    check("ovf_ready", ev_ready, 0);
    wait_idle();
    ign = 1'b1;
    {ev_x, ev_y, ev_t, ev_p} = 8'ha5;
    ev_valid = 1'b1;
    repeat (300) @(negedge clk);
    check("sat_drop", drop_count, 255);
    ev_valid = 1'b0;
    seen0 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (!tx_busy) seen0 = 1'b1;
      else if (seen0) found = 1'b1;
    end
    check("frame_start_seen", found, 1);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_tx", tx_serial, 1);
    check("mid_rst_busy", tx_busy, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_drop", drop_count, 0);
    check("mid_rst_ready", ev_ready, 1);
    rst = 1'b0;
    repeat (50) @(negedge clk);
    ign = 1'b0;
    send(8'h3c);
    wait_idle();
    check("queue_drained", q.size(), 0);
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
